// File: rtl/uart_rx_dev.sv
// uart_rx_dev: bus-side UART receiver. Deserialises 8N1 frames from rxd into a
// small FIFO and exposes DATA (sel=0) and STATUS (sel=1) registers with
// combinational read data.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a PARITY state and
// a PERR sticky flag; without it frames are 8N1 and PERR reads 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rxd_s
// ST_START | counting to the start-bit centre, reject glitches there
// ST_DATA  | sampling 8 data bits LSB first at each bit centre
// ST_PARITY| sampling the even-parity bit (parity build only)
// ST_STOP  | sampling the stop bit; push the byte or flag a framing error
// ST_BREAK | stop bit was low, waiting for the line to return high
module uart_rx_dev #(
   parameter int XLEN         = 64,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            rxd,
   input  logic            cen,
   input  logic            wr,
   input  logic            sel,
   input  logic [7:0]      wdata,
   output logic [XLEN-1:0] rdata,
   output logic            error
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      idx, idx_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic            rxd_m, rxd_s;
   logic            push, ferr_set;
   logic            par_bad, par_bad_nxt, perr_set;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wptr, rptr, count;
   logic            empty, full, pop, push_ok, ovr_set;
   logic            ovr, ferr, perr;
   logic            stat_wr;
   logic            unused_wdata;

   // two-flop synchroniser for the asynchronous serial input
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   // receive FSM state and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         par_bad <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         shreg   <= shreg_nxt;
         par_bad <= par_bad_nxt;
      end
   end

   // next-state, bit-centre sampling and push/error strobes
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      shreg_nxt   = shreg;
      par_bad_nxt = par_bad;
      push        = 1'b0;
      ferr_set    = 1'b0;
      perr_set    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rxd_s) begin
               state_nxt = ST_START;
               cnt_nxt   = CNT_HALF;
            end
         end
         ST_START: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (!rxd_s) begin
               state_nxt   = ST_DATA;
               cnt_nxt     = CNT_FULL;
               idx_nxt     = '0;
               par_bad_nxt = 1'b0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               shreg_nxt = {rxd_s, shreg[7:1]};
               cnt_nxt   = CNT_FULL;
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               // even parity: the parity bit equals the XOR of the data bits
               par_bad_nxt = rxd_s ^ (^shreg);
               perr_set    = rxd_s ^ (^shreg);
               cnt_nxt     = CNT_FULL;
               state_nxt   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (rxd_s) begin
               push      = ~par_bad;
               state_nxt = ST_IDLE;
            end else begin
               ferr_set  = 1'b1;
               state_nxt = ST_BREAK;
            end
         end
         ST_BREAK: begin
            if (rxd_s) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count   = wptr - rptr;
   assign pop     = cen & ~wr & ~sel & ~empty;
   assign push_ok = push & (~full | pop);
   assign ovr_set = push & full & ~pop;
   assign stat_wr = cen & wr & sel;
   assign error   = cen & wr & ~sel;

   // FIFO storage; contents need no reset since empty gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr[AW-1:0]] <= shreg;
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
      end
   end

   // sticky flags, write-1-to-clear with set taking priority
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         ovr  <= ovr_set  | (ovr  & ~(stat_wr & wdata[2]));
         ferr <= ferr_set | (ferr & ~(stat_wr & wdata[3]));
      end
   end

`ifdef UART_RX_PARITY_EN
   // parity error sticky flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) perr <= 1'b0;
      else       perr <= perr_set | (perr & ~(stat_wr & wdata[4]));
   end
   assign unused_wdata = ^{wdata[7:5], wdata[1:0]};
`else
   assign perr         = 1'b0;
   assign unused_wdata = ^{wdata[7:4], wdata[1:0], perr_set};
`endif

   // combinational read mux; zero when not selected or when the FIFO is empty
   always_comb begin
      rdata = '0;
      if (cen) begin
         if (!sel) begin
            if (!empty) begin
               rdata[7:0] = mem[rptr[AW-1:0]];
               rdata[8]   = 1'b1;
            end
         end else begin
            rdata[0]      = ~empty;
            rdata[1]      = full;
            rdata[2]      = ovr;
            rdata[3]      = ferr;
            rdata[4]      = perr;
            rdata[8 +: PW] = count;
         end
      end
   end

endmodule

// File: doc/uart_rx_dev.md
Name: uart_rx_dev

Overview:
- Bus-side UART receiver peripheral: the receive counterpart of the existing write-only uart sink.
- Deserialises an 8N1 serial line into bytes and buffers them in a small FIFO.
- Exposes data and status registers to the CPU through the bus slave-select interface (cen/wr/rdata/error), alongside the memory, uart and timer devices.
- Read data is combinational so the single-cycle core can consume it in the same cycle as the access.

Parameters:
- XLEN, 64, width of the rdata bus.
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 4, must be even.
- FIFO_DEPTH, 8, number of receive FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state on posedge.
- rstn  input  1  asynchronous active-low reset.
- rxd  input  1  serial input, idle high, asynchronous to clk.
- cen  input  1  device select from bus decoder.
- wr  input  1  1 = write, 0 = read; qualified by cen.
- sel  input  1  register select: 0 = DATA, 1 = STATUS.
- wdata  input  8  write data; used for STATUS clears only.
- rdata  output  XLEN  combinational read data; 0 when cen=0.
- error  output  1  combinational: cen & wr & (sel==0), i.e. write to DATA.

Behaviour:
- Reset (rstn low, async):
  - synchroniser flops = 1, FSM = IDLE, counters = 0;
  - FIFO pointers = 0 (empty), sticky flags = 0;
  - rdata/error follow their combinational definitions (both 0 with cen=0).
- Synchroniser: rxd passes two flops to give rxd_s; all sampling uses rxd_s.
- FSM, single down-counter cnt:
  - IDLE: rxd_s==0 -> START, cnt=CLKS_PER_BIT/2-1.
  - START: cnt>0 decrements. At cnt==0, sample rxd_s:
    - 0 -> DATA, cnt=CLKS_PER_BIT-1, bit index=0;
    - 1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: at cnt==0, sample into shift register LSB first and reload cnt. After bit 7 -> STOP (or PARITY, see feature), reload cnt.
  - STOP: at cnt==0, sample:
    - 1 -> push byte, go IDLE;
    - 0 -> set FERR sticky, drop byte, go BREAK.
  - BREAK: wait for rxd_s==1 -> IDLE.
- FIFO:
  - pop = cen & ~wr & (sel==0) & ~empty, registered on posedge.
  - push is accepted if ~full, or if a pop occurs in the same cycle.
  - push while full with no pop: byte dropped, OVR sticky set, contents unchanged.
  - simultaneous push and pop on empty is impossible; pop requires ~empty.
  - pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and the rest are equal.
- DATA read (sel=0): rdata[7:0] = head byte, rdata[8] = ~empty, upper bits 0.
  - Empty read returns 0 and leaves the pointers unchanged.
- STATUS read (sel=1), no side effects, upper bits 0:
  - bit0 = ~empty;
  - bit1 = full;
  - bit2 = OVR;
  - bit3 = FERR;
  - bit4 = PERR;
  - bits[11:8] = FIFO count (width log2(FIFO_DEPTH)+1).
- STATUS write: write-1-to-clear of bits 2..4 using wdata[4:2]. If a set and a clear hit the same cycle, set wins.
- A DATA write asserts error; it has no state effect.
- Reset mid-frame abandons the frame; no partial byte is pushed.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - after bit 7 the FSM enters PARITY and samples one even-parity bit at the bit centre;
  - a mismatch sets PERR sticky and the byte is dropped, but STOP is still checked;
  - frame is 8E1.
- Undefined:
  - no PARITY state, frame is 8N1;
  - PERR is held 0 and STATUS bit4 reads 0.

Test Plan:
- Reset with rxd=1, then read STATUS -> rdata=0, error=0. Read DATA -> rdata=0, FIFO pointers unchanged.
- Send 8'hA5 8N1 (16 clk/bit), wait 1 bit time, then read STATUS -> bit0=1, count=1. Read DATA -> rdata=0x1A5; following STATUS -> 0.
- rxd low pulse for 4 clks only -> FSM returns to IDLE, STATUS stays 0. Then send 8'h3C -> DATA reads 0x13C.
- Send 9 bytes 0x01..0x09 without reading:
  - STATUS -> bit1=1, bit2=1, count=8;
  - eight DATA reads -> 0x101..0x108;
  - write STATUS wdata=0x04 -> bit2 clears.
- Send 8'h55 with stop bit 0, held low 20 bit times, then idle -> FERR=1, FIFO empty. A following 8'h55 frame is received correctly (0x155).
- Write with sel=0 -> error=1 that cycle, no state change. Assert rstn low mid-byte -> all outputs and flags 0 immediately; the next full frame is received correctly.
